// File: rtl/splitter_3layer.sv
// Eight-way splitter: routes a merged, index-tagged stream into eight per-channel FIFOs.
// Optional key-order checking is enabled by defining SPLITTER_ORDER_CHECK_EN; the merged payload port is input_data since "input" is reserved.
module splitter_3layer #(
  parameter int DATA_WIDTH = 12,
  parameter int ACTIVE_MSB = 11,
  parameter int ACTIVE_LSB = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic [2:0]            input_index,
  input  logic                  vin,
  output logic                  outread,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [DATA_WIDTH-1:0] out4,
  output logic [DATA_WIDTH-1:0] out5,
  output logic [DATA_WIDTH-1:0] out6,
  output logic [DATA_WIDTH-1:0] out7,
  output logic [DATA_WIDTH-1:0] out8,
  output logic                  vout1,
  output logic                  vout2,
  output logic                  vout3,
  output logic                  vout4,
  output logic                  vout5,
  output logic                  vout6,
  output logic                  vout7,
  output logic                  vout8,
  input  logic                  inRead1,
  input  logic                  inRead2,
  input  logic                  inRead3,
  input  logic                  inRead4,
  input  logic                  inRead5,
  input  logic                  inRead6,
  input  logic                  inRead7,
  input  logic                  inRead8,
  output logic [7:0]            order_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]            rd_req;
  logic [7:0]            empty;
  logic [7:0]            full;
  logic [7:0]            push;
  logic [7:0]            pop;
  logic [DATA_WIDTH-1:0] head [8];

  assign rd_req  = {inRead8, inRead7, inRead6, inRead5, inRead4, inRead3, inRead2, inRead1};
  // Full comes from registered pointers only, so a same-cycle pop never admits a write.
  assign outread = reset & en & vin & ~full[input_index];

  for (genvar k = 0; k < 8; k++) begin : g_ch
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    assign empty[k] = (wr_ptr == rd_ptr);
    assign full[k]  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push[k]  = outread && (input_index == 3'(k));
    assign pop[k]   = en & rd_req[k] & ~empty[k];
    assign head[k]  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[k]) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop[k])  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (push[k]) mem[wr_ptr[AW-1:0]] <= input_data;
    end
  end

`ifdef SPLITTER_ORDER_CHECK_EN
  localparam int KW = ACTIVE_MSB - ACTIVE_LSB + 1;

  logic [KW-1:0] key;
  logic [7:0]    err_vec;

  assign key       = input_data[ACTIVE_MSB:ACTIVE_LSB];
  assign order_err = err_vec;

  for (genvar k = 0; k < 8; k++) begin : g_ord
    logic [KW-1:0] last_key;
    logic          key_valid;
    logic          err;

    assign err_vec[k] = err;

    always_ff @(posedge clk) begin
      if (!reset) begin
        key_valid <= 1'b0;
        err       <= 1'b0;
      end else if (push[k]) begin
        if (key_valid && (key < last_key)) err <= 1'b1;
        last_key  <= key;
        key_valid <= 1'b1;
      end
    end
  end
`else
  assign order_err = '0;
`endif

  assign out1  = head[0];
  assign out2  = head[1];
  assign out3  = head[2];
  assign out4  = head[3];
  assign out5  = head[4];
  assign out6  = head[5];
  assign out7  = head[6];
  assign out8  = head[7];
  assign vout1 = ~empty[0];
  assign vout2 = ~empty[1];
  assign vout3 = ~empty[2];
  assign vout4 = ~empty[3];
  assign vout5 = ~empty[4];
  assign vout6 = ~empty[5];
  assign vout7 = ~empty[6];
  assign vout8 = ~empty[7];

endmodule

// File: tb/tb_splitter_3layer.sv
// Directed bench for splitter_3layer: per-channel expected-data queues filled on accept, drained on pop.
module tb_splitter_3layer;

  localparam int DW    = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          vin = 1'b0;
  logic [DW-1:0] input_data = '0;
  logic [2:0]    input_index = '0;
  logic [7:0]    rd = '0;
  logic          outread;
  logic [DW-1:0] out_w [8];
  logic [7:0]    vout;
  logic [7:0]    order_err;

  logic [DW-1:0] sb [8][$];
  logic [5:0]    last_key [8];
  logic          key_v [8];
  logic [7:0]    exp_err = '0;
  logic          last_acc = 1'b0;
  int            checks = 0;
  int            failures = 0;
  int            sent;
  logic [6:0]    pattern;

  always #5 clk = ~clk;

  splitter_3layer #(.DATA_WIDTH(DW), .ACTIVE_MSB(11), .ACTIVE_LSB(6), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .input_data(input_data), .input_index(input_index),
    .vin(vin), .outread(outread),
    .out1(out_w[0]), .out2(out_w[1]), .out3(out_w[2]), .out4(out_w[3]),
    .out5(out_w[4]), .out6(out_w[5]), .out7(out_w[6]), .out8(out_w[7]),
    .vout1(vout[0]), .vout2(vout[1]), .vout3(vout[2]), .vout4(vout[3]),
    .vout5(vout[4]), .vout6(vout[5]), .vout7(vout[6]), .vout8(vout[7]),
    .inRead1(rd[0]), .inRead2(rd[1]), .inRead3(rd[2]), .inRead4(rd[3]),
    .inRead5(rd[4]), .inRead6(rd[5]), .inRead7(rd[6]), .inRead8(rd[7]),
    .order_err(order_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at negedge against the queues, then update the model at posedge.
  task automatic cycle();
    logic acc;
    @(negedge clk);
    acc = reset && en && vin && (sb[input_index].size() < DEPTH);
    chk("outread", 32'(outread), 32'(acc));
    chk("order_err", 32'(order_err), 32'(exp_err));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("vout%0d", k + 1), 32'(vout[k]), 32'(sb[k].size() != 0));
      if (sb[k].size() != 0) chk($sformatf("out%0d", k + 1), 32'(out_w[k]), 32'(sb[k][0]));
    end
    @(posedge clk);
    if (!reset) begin
      for (int k = 0; k < 8; k++) begin
        sb[k].delete();
        key_v[k] = 1'b0;
      end
      exp_err = '0;
    end else begin
      for (int k = 0; k < 8; k++)
        if (en && rd[k] && sb[k].size() != 0) void'(sb[k].pop_front());
      if (acc) begin
`ifdef SPLITTER_ORDER_CHECK_EN
        if (key_v[input_index] && (input_data[11:6] < last_key[input_index])) exp_err[input_index] = 1'b1;
        last_key[input_index] = input_data[11:6];
        key_v[input_index]    = 1'b1;
`endif
        sb[input_index].push_back(input_data);
      end
    end
    last_acc = acc;
    #1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      key_v[k]    = 1'b0;
      last_key[k] = '0;
    end
    @(posedge clk);
    #1;
    cycle();
    reset = 1'b1;
    en    = 1'b1;

    // Route: one word per channel, all consumers reading.
    rd = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      vin = 1'b1;
      input_index = 3'(k);
      input_data = 12'h040 + 12'(k);
      cycle();
    end
    vin = 1'b0;
    cycle();
    cycle();

    // Fill and backpressure on channel 3.
    rd = '0;
    sent = 0;
    pattern = '0;
    for (int c = 0; c < 7; c++) begin
      vin = 1'b1;
      input_index = 3'd2;
      input_data = 12'h100 + 12'(sent);
      rd[2] = (c == 5);
      cycle();
      pattern[c] = last_acc;
      if (last_acc) sent++;
    end
    chk("fill_pattern", 32'(pattern), 32'(7'b1001111));
    chk("fill_sent", 32'(sent), 32'd5);
    vin = 1'b0;
    rd = 8'h04;
    repeat (6) cycle();

    // Simultaneous push/pop on channel 5 with two words resident.
    rd = '0;
    for (int i = 0; i < 2; i++) begin
      vin = 1'b1;
      input_index = 3'd4;
      input_data = 12'h200 + 12'(i);
      cycle();
    end
    rd = 8'h10;
    for (int i = 2; i < 22; i++) begin
      input_data = 12'h200 + 12'(i);
      cycle();
      chk("pushpop_occ", 32'(sb[4].size()), 32'd2);
    end
    vin = 1'b0;
    repeat (3) cycle();

    // Order check on channel 1: keys 5, 5, 3.
    rd = 8'h01;
    vin = 1'b1;
    input_index = 3'd0;
    input_data = {6'd5, 6'h01}; cycle();
    input_data = {6'd5, 6'h02}; cycle();
    input_data = {6'd3, 6'h03}; cycle();
    vin = 1'b0;
    cycle();
`ifdef SPLITTER_ORDER_CHECK_EN
    chk("order_seq", 32'(order_err), 32'h01);
`else
    chk("order_seq", 32'(order_err), 32'h00);
`endif
    repeat (2) cycle();

    // Buffer three words, then hold with en low.
    rd = '0;
    vin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      input_data = {6'd9, 6'(i)};
      cycle();
    end
    en = 1'b0;
    rd = 8'h01;
    repeat (3) cycle();
    chk("en_hold_occ", 32'(sb[0].size()), 32'd3);

    // Reset with words buffered; keep reset low during the following check.
    reset = 1'b0;
    cycle();
    cycle();
    chk("rst_vout", 32'(vout), 32'h00);
    chk("rst_order_err", 32'(order_err), 32'h00);
    chk("rst_outread", 32'(outread), 32'h0);

    reset = 1'b1;
    en = 1'b1;
    rd = 8'hFF;
    input_index = 3'd7;
    input_data = 12'h0AB;
    cycle();
    vin = 1'b0;
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
